// File: rtl/axibram_cmd_ser_pkg.sv
// Shared constants, FSM encoding and frame-byte formatter for the write-side
// command serializer.
package axibram_cmd_ser_pkg;

  localparam int FRAME_LEN = 6;

  localparam logic [2:0] BYTE_B0 = 3'd0;
  localparam logic [2:0] BYTE_B1 = 3'd1;
  localparam logic [2:0] BYTE_B2 = 3'd2;
  localparam logic [2:0] BYTE_B3 = 3'd3;
  localparam logic [2:0] BYTE_B4 = 3'd4;
  localparam logic [2:0] BYTE_B5 = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B0   = 3'd1,
    ST_B1   = 3'd2,
    ST_B2   = 3'd3,
    ST_B3   = 3'd4,
    ST_B4   = 3'd5,
    ST_B5   = 3'd6
  } ser_state_e;

  // Byte index of a frame state (ST_IDLE maps to an unused index).
  function automatic logic [2:0] state_idx(input ser_state_e st);
    return 3'(st) - 3'd1;
  endfunction

  // The address is zero-extended to 12 bits, so its high bits land in the LSBs of B1.
  function automatic logic [7:0] frame_byte(input logic [3:0]  stb,
                                            input logic [11:0] addr,
                                            input logic [31:0] data,
                                            input logic [2:0]  idx);
    case (idx)
      BYTE_B0: return addr[7:0];
      BYTE_B1: return {stb, addr[11:8]};
      BYTE_B2: return data[7:0];
      BYTE_B3: return data[15:8];
      BYTE_B4: return data[23:16];
      BYTE_B5: return data[31:24];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/axibram_cmd_ser_fifo.sv
// Register FIFO with occupancy count; a push into a full FIFO is refused
// even when a pop happens in the same cycle.
module fifo_cnt_W_D #(
  parameter  int W  = 8,
  parameter  int D  = 4,
  localparam int AW = $clog2(D)
) (
  input  logic         aclk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         nempty,
  output logic         full,
  output logic [AW:0]  count
);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(D));
  assign nempty  = (count != '0);
  assign do_push = push && !full;
  assign do_pop  = pop && nempty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; only the pointers and count define validity.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axibram_cmd_ser.sv
// Window-decoded BRAM write capture into a word FIFO, replayed as 6-byte
// frames on a byte-wide command bus.
module axibram_cmd_ser
  import axibram_cmd_ser_pkg::*;
#(
  parameter int                      ADDRESS_BITS = 10,
  parameter logic [ADDRESS_BITS-1:0] ADDR_MASK    = ADDRESS_BITS'(10'h300),
  parameter logic [ADDRESS_BITS-1:0] ADDR_MATCH   = ADDRESS_BITS'(10'h100),
  parameter int                      FIFO_DEPTH   = 4
) (
  input  logic                    aclk,
  input  logic                    rst,
  input  logic [ADDRESS_BITS-1:0] pre_awaddr,
  input  logic                    start_burst,
  output logic                    dev_ready,
  input  logic [ADDRESS_BITS-1:0] bram_waddr,
  input  logic                    bram_wen,
  input  logic [3:0]              bram_wstb,
  input  logic [31:0]             bram_wdata,
  output logic [7:0]              cmd_ad,
  output logic                    cmd_stb,
  output logic                    cmd_start,
  output logic                    overflow
);

  localparam int EW = 4 + ADDRESS_BITS + 32;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          sel_r, accept, pop, nempty, full;
  logic [CW-1:0] count;
  logic [EW-1:0] head, frame_r, src;
  ser_state_e    state, next_state;
  logic [7:0]    nxt_ad;
  logic          nxt_stb, nxt_start;

  assign accept    = bram_wen && sel_r && (bram_wstb != 4'b0);
  // Two slots of headroom because the bridge acts on a registered copy.
  assign dev_ready = (count <= CW'(FIFO_DEPTH - 2));
  assign pop       = nempty && (state == ST_IDLE || state_idx(state) == 3'(FRAME_LEN - 1));

  fifo_cnt_W_D #(.W(EW), .D(FIFO_DEPTH)) u_fifo (
    .aclk   (aclk),
    .rst    (rst),
    .push   (accept),
    .wdata  ({bram_wstb, bram_waddr, bram_wdata}),
    .pop    (pop),
    .rdata  (head),
    .nempty (nempty),
    .full   (full),
    .count  (count)
  );

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      sel_r    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (start_burst) sel_r <= ((pre_awaddr & ADDR_MASK) == ADDR_MATCH);
      if (accept && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      frame_r   <= '0;
      cmd_ad    <= 8'h00;
      cmd_stb   <= 1'b0;
      cmd_start <= 1'b0;
    end else begin
      state     <= next_state;
      if (pop) frame_r <= head;
      cmd_ad    <= nxt_ad;
      cmd_stb   <= nxt_stb;
      cmd_start <= nxt_start;
    end
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (nempty) next_state = ST_B0;
      ST_B5:   next_state = nempty ? ST_B0 : ST_IDLE;
      default: next_state = ser_state_e'(state + 3'd1);
    endcase
  end

  // Outputs are computed for the next state and registered, taking the fresh
  // FIFO head on the cycle it is popped.
  always_comb begin
    src       = pop ? head : frame_r;
    nxt_stb   = (next_state != ST_IDLE);
    nxt_start = (next_state == ST_B0);
    nxt_ad    = 8'h00;
    if (nxt_stb)
      nxt_ad = frame_byte(src[EW-1 -: 4], 12'(src[32 +: ADDRESS_BITS]), src[31:0],
                          state_idx(next_state));
  end

endmodule
